// File: rtl/sdram_cpu_bridge.sv
// CPU 16-bit word port to 32-bit SDRAM controller bridge with a one-entry pair buffer (read hits, write-through).
// Latency: read hit acks 1 cycle after the request; misses and writes wait on controller handshakes.
// Backpressure: busy is high outside IDLE and requests arriving while busy are dropped; any wait times out with an error ack.
module sdram_cpu_bridge #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter bit BUF_EN         = 1'b1
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic [23:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic        busy,
    output logic [23:0] mem_address,
    output logic        mem_req_read,
    output logic        mem_req_write,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    input  logic        mem_data_valid,
    input  logic        mem_write_complete
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, RD_DROP, MERGE, WR_REQ, WR_WAIT, WR_DROP
    } state_t;

    localparam logic [9:0] TMO = 10'(TIMEOUT_CYCLES);

    state_t      state;
    logic        op_wr;
    logic        half;
    logic [22:0] tag;
    logic [15:0] wdata;
    logic [31:0] buf_dat;
    logic        buf_valid;
    logic [22:0] buf_tag;
    logic [9:0]  tcnt;

    logic        hit;
    logic [31:0] merged;
    logic        in_wait;
    logic        evt;

    // Hit is judged against the live CPU address since requests are only taken in IDLE.
    assign hit     = BUF_EN && buf_valid && (cpu_addr[23:1] == buf_tag);
    assign merged  = half ? {wdata, buf_dat[15:0]} : {buf_dat[31:16], wdata};
    assign busy    = (state != IDLE);
    assign in_wait = (state == RD_WAIT) || (state == RD_DROP) ||
                     (state == WR_WAIT) || (state == WR_DROP);
    // The event that lets each wait/drop state move on.
    assign evt     = ((state == RD_WAIT) &&  mem_data_valid)     ||
                     ((state == RD_DROP) && !mem_data_valid)     ||
                     ((state == WR_WAIT) &&  mem_write_complete) ||
                     ((state == WR_DROP) && !mem_write_complete);

    // Bridge FSM: request capture, controller handshakes, pair buffer and timeout.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            op_wr         <= 1'b0;
            half          <= 1'b0;
            tag           <= '0;
            wdata         <= '0;
            buf_dat       <= '0;
            buf_valid     <= 1'b0;
            buf_tag       <= '0;
            tcnt          <= '0;
            cpu_rdata     <= '0;
            cpu_ack       <= 1'b0;
            cpu_err       <= 1'b0;
            mem_address   <= '0;
            mem_req_read  <= 1'b0;
            mem_req_write <= 1'b0;
            mem_data_in   <= '0;
        end else begin
            cpu_ack <= 1'b0;
            cpu_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_wr) begin
                        // Write wins over a simultaneous read; a hit skips the fill read.
                        op_wr       <= 1'b1;
                        half        <= cpu_addr[0];
                        tag         <= cpu_addr[23:1];
                        wdata       <= cpu_wdata;
                        mem_address <= {cpu_addr[23:1], 1'b0};
                        if (hit) begin
                            state <= MERGE;
                        end else begin
                            state        <= RD_REQ;
                            mem_req_read <= 1'b1;
                        end
                    end else if (cpu_rd) begin
                        if (hit) begin
                            cpu_ack   <= 1'b1;
                            cpu_rdata <= cpu_addr[0] ? buf_dat[31:16] : buf_dat[15:0];
                        end else begin
                            op_wr        <= 1'b0;
                            half         <= cpu_addr[0];
                            tag          <= cpu_addr[23:1];
                            mem_address  <= {cpu_addr[23:1], 1'b0};
                            state        <= RD_REQ;
                            mem_req_read <= 1'b1;
                        end
                    end
                end
                RD_REQ: begin
                    mem_req_read <= 1'b0;
                    tcnt         <= '0;
                    state        <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (evt) begin
                        buf_dat   <= mem_data_out;
                        buf_valid <= BUF_EN;
                        buf_tag   <= tag;
                        if (!op_wr) begin
                            cpu_ack   <= 1'b1;
                            cpu_rdata <= half ? mem_data_out[31:16] : mem_data_out[15:0];
                        end
                        tcnt  <= '0;
                        state <= RD_DROP;
                    end
                end
                RD_DROP: begin
                    if (evt) begin
                        tcnt  <= '0;
                        state <= op_wr ? MERGE : IDLE;
                    end
                end
                MERGE: begin
                    buf_dat       <= merged;
                    mem_data_in   <= merged;
                    mem_req_write <= 1'b1;
                    state         <= WR_REQ;
                end
                WR_REQ: begin
                    mem_req_write <= 1'b0;
                    tcnt          <= '0;
                    state         <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (evt) begin
                        cpu_ack <= 1'b1;
                        tcnt    <= '0;
                        state   <= WR_DROP;
                    end
                end
                WR_DROP: begin
                    if (evt) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Shared timeout for all wait/drop states; overrides the case above when it fires.
            if (in_wait && !evt) begin
                if (tcnt == TMO) begin
                    cpu_ack   <= 1'b1;
                    cpu_err   <= 1'b1;
                    cpu_rdata <= '0;
                    buf_valid <= 1'b0;
                    state     <= IDLE;
                end else begin
                    tcnt <= tcnt + 10'd1;
                end
            end
        end
    end

endmodule
